// File: rtl/coax_line_ctrl_pkg.sv
// Shared coax link constants and timer helpers used by the line controller,
// transmitter and receiver.
package coax_line_ctrl_pkg;

  localparam int unsigned COAX_CLOCKS_PER_BIT = 8;
  localparam int unsigned COAX_TIMER_W        = 16;

  typedef logic [COAX_TIMER_W-1:0] coax_timer_t;

  // Number of system clocks spanned by a given count of coax bit times.
  function automatic coax_timer_t coax_bit_clocks(input int unsigned bits,
                                                  input int unsigned cpb);
    return coax_timer_t'(bits * cpb);
  endfunction

endpackage

// File: rtl/coax_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
module coax_down_counter
  import coax_line_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  coax_timer_t load_val_i,
  input  logic        dec_i,
  output coax_timer_t count_o,
  output logic        zero_o
);

  coax_timer_t count_q;
  coax_timer_t count_d;

  // Load has priority over decrement; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - coax_timer_t'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/coax_line_ctrl.sv
// Half-duplex coax line controller: sequences transmit, line turnaround and
// optional response reception, owning the line-driver and receiver enables.
module coax_line_ctrl
  import coax_line_ctrl_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT   = COAX_CLOCKS_PER_BIT,
  parameter int unsigned TURNAROUND_BITS  = 2,
  parameter int unsigned RESPONSE_TIMEOUT = 1152
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_expect_response,
  output logic cmd_ready,
  output logic tx_start,
  input  logic tx_active,
  output logic tx_line_enable,
  output logic rx_enable,
  input  logic rx_active,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic tx_error,
  output logic unsolicited
);

  localparam coax_timer_t TX_WAIT_LOAD = coax_bit_clocks(32'd4, CLOCKS_PER_BIT);
  localparam coax_timer_t TURN_LOAD    = coax_bit_clocks(TURNAROUND_BITS, CLOCKS_PER_BIT);
  localparam coax_timer_t RESP_LOAD    = coax_timer_t'(RESPONSE_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_START,
    ST_TX_WAIT,
    ST_TX_BUSY,
    ST_TURNAROUND,
    ST_RX_WAIT,
    ST_RX_BUSY
  } state_e;

  state_e      state_q, state_d;
  logic        expect_q, expect_d;
  logic        rx_active_q;

  logic        tmr_load;
  coax_timer_t tmr_load_val;
  logic        tmr_dec;
  coax_timer_t tmr_count;
  logic        tmr_zero;
  logic        tmr_expired;

  logic        done_d, timeout_d, tx_error_d, unsol_d;

  logic        tx_start_q, tx_line_en_q, rx_en_q, busy_q;
  logic        done_q, timeout_q, tx_error_q, unsol_q;

  coax_down_counter u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  // A state loaded with N leaves on the edge where the count would reach 0.
  assign tmr_expired = tmr_zero || (tmr_count == coax_timer_t'(1));

  // The receiver has priority over a new command while idle.
  assign cmd_ready = (state_q == ST_IDLE) && !rx_active;

  // Next state, timer control and completion pulses.
  always_comb begin
    state_d      = state_q;
    expect_d     = expect_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    tx_error_d   = 1'b0;
    unsol_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        unsol_d = rx_active && !rx_active_q;
        if (cmd_valid && !rx_active) begin
          state_d      = ST_TX_START;
          expect_d     = cmd_expect_response;
          tmr_load     = 1'b1;
          tmr_load_val = TX_WAIT_LOAD;
        end
      end
      ST_TX_START: begin
        tmr_dec = 1'b1;
        state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        tmr_dec = 1'b1;
        if (tx_active) begin
          state_d = ST_TX_BUSY;
        end else if (tmr_expired) begin
          state_d    = ST_IDLE;
          tx_error_d = 1'b1;
        end
      end
      ST_TX_BUSY: begin
        if (!tx_active) begin
          state_d      = ST_TURNAROUND;
          tmr_load     = 1'b1;
          tmr_load_val = TURN_LOAD;
        end
      end
      ST_TURNAROUND: begin
        tmr_dec = 1'b1;
        if (tmr_expired) begin
          if (expect_q) begin
            state_d      = ST_RX_WAIT;
            tmr_load     = 1'b1;
            tmr_load_val = RESP_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RX_WAIT: begin
        tmr_dec = 1'b1;
        if (rx_active) begin
          state_d = ST_RX_BUSY;
        end else if (tmr_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_RX_BUSY: begin
        if (!rx_active) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with outputs registered from the next state, so the
  // line enables change on the same edge as the state and are never both set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      expect_q     <= 1'b0;
      rx_active_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_line_en_q <= 1'b0;
      rx_en_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      tx_error_q   <= 1'b0;
      unsol_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      expect_q     <= expect_d;
      rx_active_q  <= rx_active;
      tx_start_q   <= (state_d == ST_TX_START);
      tx_line_en_q <= (state_d == ST_TX_START) || (state_d == ST_TX_WAIT);
      rx_en_q      <= (state_d == ST_IDLE) || (state_d == ST_RX_WAIT) ||
                      (state_d == ST_RX_BUSY);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      tx_error_q   <= tx_error_d;
      unsol_q      <= unsol_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_line_enable = tx_line_en_q;
  assign rx_enable      = rx_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign tx_error       = tx_error_q;
  assign unsolicited    = unsol_q;

endmodule

// File: tb/tb_coax_line_ctrl.sv
// Self-checking bench for coax_line_ctrl with randomized transaction timing.
module tb_coax_line_ctrl;

  localparam int CPB      = 8;
  localparam int TA_BITS  = 2;
  localparam int RT       = 100;

  // Reference timing derived from the link rules: each timed phase lasts its
  // loaded count in clocks, measured from the edge that enters the phase.
  localparam int EXP_TX_ERR_LAT = 4 * CPB;
  localparam int EXP_TURN_LAT   = TA_BITS * CPB;
  localparam int EXP_RESP_LAT   = RT;

  logic clk;
  logic reset;
  logic cmd_valid;
  logic cmd_expect_response;
  logic cmd_ready;
  logic tx_start;
  logic tx_active;
  logic tx_line_enable;
  logic rx_enable;
  logic rx_active;
  logic busy;
  logic done;
  logic timeout;
  logic tx_error;
  logic unsolicited;

  int checks;
  int errors;
  logic excl_viol;
  int   excl_samples;

  coax_line_ctrl #(
    .CLOCKS_PER_BIT   (CPB),
    .TURNAROUND_BITS  (TA_BITS),
    .RESPONSE_TIMEOUT (RT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_expect_response (cmd_expect_response),
    .cmd_ready           (cmd_ready),
    .tx_start            (tx_start),
    .tx_active           (tx_active),
    .tx_line_enable      (tx_line_enable),
    .rx_enable           (rx_enable),
    .rx_active           (rx_active),
    .busy                (busy),
    .done                (done),
    .timeout             (timeout),
    .tx_error            (tx_error),
    .unsolicited         (unsolicited)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line enables must never overlap in any cycle.
  initial begin
    excl_viol    = 1'b0;
    excl_samples = 0;
  end
  always @(negedge clk) begin
    excl_samples <= excl_samples + 1;
    if (tx_line_enable && rx_enable) excl_viol <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({tx_line_enable, rx_enable, tx_start, busy, done, timeout, tx_error, unsolicited} !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {tx_line_enable, rx_enable, tx_start, busy, done, timeout, tx_error, unsolicited}, 8'b0100_0000);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({cmd_ready, busy, rx_enable, tx_line_enable} !== 4'b1010) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", {cmd_ready, busy, rx_enable, tx_line_enable}, 4'b1010);
    end
  endtask

  task automatic test_no_response();
    int d0;
    int len;
    int lat;
    bit saw;
    for (int it = 0; it < 3; it++) begin
      d0  = int'($urandom_range(0, 5));
      len = int'($urandom_range(3, 40));
      saw = 1'b0;
      lat = -1;
      cmd_valid = 1'b1;
      cmd_expect_response = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      checks++;
      if ({tx_start, tx_line_enable, rx_enable, busy} !== 4'b1101) begin
        errors++;
        $display("FAIL tx_start_cycle1: got %b want %b", {tx_start, tx_line_enable, rx_enable, busy}, 4'b1101);
      end
      repeat (d0) step();
      tx_active = 1'b1;
      for (int k = 0; k < len; k++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        step();
        if (tx_start || cmd_ready || done) saw = 1'b1;
      end
      cmd_valid = 1'b0;
      tx_active = 1'b0;
      step();
      checks++;
      if ({tx_line_enable, rx_enable, busy} !== 3'b001) begin
        errors++;
        $display("FAIL turnaround_quiet: got %b want %b", {tx_line_enable, rx_enable, busy}, 3'b001);
      end
      for (int k = 1; k <= 200; k++) begin
        step();
        if (done) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat != EXP_TURN_LAT) begin
        errors++;
        $display("FAIL done_latency: got %0d want %0d", lat, EXP_TURN_LAT);
      end
      checks++;
      if ({busy, cmd_ready, rx_enable, timeout} !== 4'b0110) begin
        errors++;
        $display("FAIL idle_after_done: got %b want %b", {busy, cmd_ready, rx_enable, timeout}, 4'b0110);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_one_clock: got %b want 0", done);
      end
      checks++;
      if (saw !== 1'b0) begin
        errors++;
        $display("FAIL cmd_ignored_when_busy: got %b want 0", saw);
      end
    end
  endtask

  task automatic test_with_response(input int dly, input int hold);
    int len;
    int lat;
    bit saw_to;
    bit saw_bad;
    len     = int'($urandom_range(3, 40));
    lat     = -1;
    saw_to  = 1'b0;
    saw_bad = 1'b0;
    cmd_valid = 1'b1;
    cmd_expect_response = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_expect_response = 1'b0;
    tx_active = 1'b1;
    repeat (len) step();
    tx_active = 1'b0;
    step();
    for (int k = 1; k <= 200; k++) begin
      step();
      if (rx_enable) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != EXP_TURN_LAT) begin
      errors++;
      $display("FAIL rx_enable_latency: got %0d want %0d", lat, EXP_TURN_LAT);
    end
    for (int k = 1; k < dly; k++) begin
      step();
      if (timeout || done) saw_to = 1'b1;
    end
    rx_active = 1'b1;
    for (int k = 0; k < hold; k++) begin
      step();
      if (timeout) saw_to = 1'b1;
      if (done || !busy || !rx_enable || tx_line_enable) saw_bad = 1'b1;
    end
    rx_active = 1'b0;
    step();
    checks++;
    if ({done, busy, timeout, cmd_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL rx_done (dly %0d): got %b want %b", dly, {done, busy, timeout, cmd_ready}, 4'b1001);
    end
    checks++;
    if ({saw_to, saw_bad} !== 2'b00) begin
      errors++;
      $display("FAIL rx_frame_clean (dly %0d): got %b want %b", dly, {saw_to, saw_bad}, 2'b00);
    end
    step();
  endtask

  task automatic test_timeout();
    int lat;
    cmd_valid = 1'b1;
    cmd_expect_response = 1'b1;
    step();
    cmd_valid = 1'b0;
    tx_active = 1'b1;
    repeat (int'($urandom_range(3, 40))) step();
    tx_active = 1'b0;
    step();
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (rx_enable) break;
    end
    for (int k = 1; k <= 300; k++) begin
      step();
      if (timeout) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != EXP_RESP_LAT) begin
      errors++;
      $display("FAIL timeout_latency: got %0d want %0d", lat, EXP_RESP_LAT);
    end
    checks++;
    if ({busy, cmd_ready, rx_enable, done} !== 4'b0110) begin
      errors++;
      $display("FAIL idle_after_timeout: got %b want %b", {busy, cmd_ready, rx_enable, done}, 4'b0110);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_one_clock: got %b want 0", timeout);
    end
  endtask

  task automatic test_tx_error();
    int lat;
    lat = -1;
    cmd_valid = 1'b1;
    cmd_expect_response = 1'($urandom_range(0, 1));
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (tx_error) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != EXP_TX_ERR_LAT) begin
      errors++;
      $display("FAIL tx_error_latency: got %0d want %0d", lat, EXP_TX_ERR_LAT);
    end
    checks++;
    if ({tx_line_enable, busy, rx_enable, done} !== 4'b0010) begin
      errors++;
      $display("FAIL line_released_on_tx_error: got %b want %b", {tx_line_enable, busy, rx_enable, done}, 4'b0010);
    end
    step();
    checks++;
    if ({tx_error, tx_line_enable, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL after_tx_error: got %b want %b", {tx_error, tx_line_enable, cmd_ready}, 3'b001);
    end
  endtask

  task automatic test_collision();
    int pulses;
    int gap;
    int width;
    int seen;
    rx_active = 1'b0;
    step();
    cmd_valid = 1'b1;
    cmd_expect_response = 1'b0;
    rx_active = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL cmd_ready_collision: got %b want 0", cmd_ready);
    end
    step();
    checks++;
    if ({tx_start, unsolicited, busy} !== 3'b010) begin
      errors++;
      $display("FAIL collision_edge: got %b want %b", {tx_start, unsolicited, busy}, 3'b010);
    end
    step();
    checks++;
    if ({tx_start, unsolicited, busy} !== 3'b000) begin
      errors++;
      $display("FAIL collision_hold: got %b want %b", {tx_start, unsolicited, busy}, 3'b000);
    end
    cmd_valid = 1'b0;
    rx_active = 1'b0;
    step();
    // Each rising edge of an idle-line frame yields exactly one pulse.
    pulses = int'($urandom_range(2, 5));
    seen = 0;
    for (int p = 0; p < pulses; p++) begin
      gap   = int'($urandom_range(1, 5));
      width = int'($urandom_range(1, 5));
      rx_active = 1'b0;
      for (int k = 0; k < gap; k++) begin
        step();
        if (unsolicited) seen++;
      end
      rx_active = 1'b1;
      for (int k = 0; k < width; k++) begin
        step();
        if (unsolicited) seen++;
      end
    end
    rx_active = 1'b0;
    step();
    if (unsolicited) seen++;
    step();
    checks++;
    if (seen != pulses) begin
      errors++;
      $display("FAIL unsolicited_count: got %0d want %0d", seen, pulses);
    end
  endtask

  task automatic test_reset_mid_tx();
    bit saw;
    saw = 1'b0;
    cmd_valid = 1'b1;
    cmd_expect_response = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if (tx_line_enable !== 1'b1) begin
      errors++;
      $display("FAIL tx_wait_line_on: got %b want 1", tx_line_enable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tx_line_enable, rx_enable, busy, tx_start} !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset_tx_wait: got %b want %b", {tx_line_enable, rx_enable, busy, tx_start}, 4'b0100);
    end
    step();
    reset = 1'b0;
    step();
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    tx_active = 1'b1;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tx_line_enable, rx_enable, busy} !== 3'b010) begin
      errors++;
      $display("FAIL async_reset_tx_busy: got %b want %b", {tx_line_enable, rx_enable, busy}, 3'b010);
    end
    tx_active = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done || timeout || tx_error || busy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL no_pulse_after_reset: got %b want 0", saw);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_expect_response = 1'b0;
    tx_active = 1'b0;
    rx_active = 1'b0;

    test_reset();
    test_no_response();
    test_with_response(20, 50);
    test_with_response(int'($urandom_range(1, RT - 1)), int'($urandom_range(1, 60)));
    test_with_response(RT, int'($urandom_range(1, 20)));
    test_timeout();
    test_tx_error();
    test_collision();
    test_reset_mid_tx();

    checks++;
    if (excl_viol !== 1'b0) begin
      errors++;
      $display("FAIL line_enable_exclusive: got overlap=%b over %0d cycles want 0", excl_viol, excl_samples);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coax_line_ctrl.md
COAX_LINE_CTRL -- requirements
Module: coax_line_ctrl

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 8, meaning system clocks per coax bit time.
REQ-002 SHALL have parameter TURNAROUND_BITS, default 2, meaning line-quiet bit times between TX end and RX enable.
REQ-003 SHALL have parameter RESPONSE_TIMEOUT, default 1152, meaning clocks to wait for a response (1..65535).
REQ-004 Ports, in this order:
- clk  in  1  system clock, one clock domain.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host requests a transmission.
- cmd_expect_response  in  1  response expected; sampled with cmd_valid.
- cmd_ready  out  1  controller accepts cmd_valid this cycle.
- tx_start  out  1  one-clock start pulse to the transmitter.
- tx_active  in  1  transmitter is sending.
- tx_line_enable  out  1  line driver enable.
- rx_enable  out  1  receiver input enable.
- rx_active  in  1  receiver is in a frame.
- busy  out  1  controller not idle.
- done  out  1  one-clock pulse on transaction complete.
- timeout  out  1  one-clock pulse when no response arrives.
- tx_error  out  1  one-clock pulse when the transmitter never went active.
- unsolicited  out  1  one-clock pulse when rx_active rises while idle.

Function
REQ-005 SHALL implement states IDLE, TX_START, TX_WAIT, TX_BUSY, TURNAROUND, RX_WAIT, RX_BUSY; all outputs except cmd_ready SHALL be registered.
REQ-006 cmd_ready SHALL be combinational: (state==IDLE) & ~rx_active.
REQ-007 IDLE: rx_enable=1, tx_line_enable=0; cmd_valid&cmd_ready -> TX_START, latch cmd_expect_response.
REQ-008 rx_active and cmd_valid in the same IDLE cycle: the receiver SHALL win, the command SHALL NOT be accepted, and no state change SHALL occur.
REQ-009 rx_active rising edge in IDLE SHALL pulse unsolicited for one clock; the state SHALL remain IDLE.
REQ-010 TX_START: tx_line_enable=1, rx_enable=0, and tx_start=1 for exactly one clock. Next state is TX_WAIT. Load timer = 4*CLOCKS_PER_BIT.
REQ-011 TX_WAIT: on tx_active -> TX_BUSY. If the timer reaches 0 first -> IDLE, with tx_error pulse and tx_line_enable dropped.
REQ-012 TX_BUSY: when tx_active is low -> TURNAROUND. tx_line_enable=0 from entry. Load timer = TURNAROUND_BITS*CLOCKS_PER_BIT.
REQ-013 TURNAROUND: tx_line_enable=0, rx_enable=0. When the timer reaches 0:
- if the latched expect=1 -> RX_WAIT, load timer = RESPONSE_TIMEOUT;
- otherwise -> IDLE with done pulse.
REQ-014 RX_WAIT: rx_enable=1. On rx_active -> RX_BUSY. If the timer reaches 0 first -> IDLE with timeout pulse.
REQ-015 RX_WAIT, rx_active in the same cycle the timer reaches 0: rx_active SHALL win (-> RX_BUSY, no timeout).
REQ-016 RX_BUSY: rx_enable=1. On falling rx_active -> IDLE with done pulse.
REQ-017 The timer SHALL be 16-bit unsigned and decrement by 1 per clock in timed states. A state whose loaded count is N SHALL exit exactly N clocks after entry. The timer SHALL saturate at 0, never wrap.
REQ-018 tx_line_enable and rx_enable SHALL never both be 1 in any cycle.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 cmd_valid outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-021 Reset SHALL act asynchronously and return the block to IDLE with timer=0 and latched expect=0.
REQ-022 While in reset, outputs SHALL be:
- tx_line_enable=0, rx_enable=1;
- tx_start, busy, done, timeout, tx_error, unsolicited = 0.
REQ-023 Reset mid-transaction SHALL release the line immediately and emit no done or timeout pulse.

Structure
REQ-024 CLOCKS_PER_BIT default SHALL come from the shared coax constants include, also used by transmitter and receiver. State encodings SHALL stay local.
REQ-025 One sub-module is natural: coax_down_counter (16-bit loadable, saturating down-counter with zero flag).

Verification
REQ-026 Defaults, RESPONSE_TIMEOUT=100. cmd_valid with expect=0, tx_active high 3..40 -> tx_start at cycle 1; done exactly 16 clocks after tx_active falls; busy low after.
REQ-027 Expect=1, tx_active pulse, rx_active high 20 clocks after rx_enable rises, for 50 clocks -> done on the clock after rx_active falls; timeout never.
REQ-028 Expect=1, no rx_active -> timeout pulse exactly 100 clocks after RX_WAIT entry; then IDLE, cmd_ready=1.
REQ-029 tx_active never asserted -> tx_error 32 clocks after TX_START; tx_line_enable=0 the next cycle.
REQ-030 Collision/idle checks:
- cmd_valid and rx_active rising in the same idle cycle -> no tx_start, unsolicited=1, state IDLE.
- Reset asserted during TX_BUSY -> tx_line_enable=0 without waiting for a clock edge.
- Assert on every cycle that tx_line_enable & rx_enable == 0.
